// File: rtl/sector_cache_adam.sv
// sector_cache_adam: multi-slot write-back sector cache between the Adam drive controller and the SD block interface.
// Round-robin eviction, dirty write-back, flush-all, and image bounds checking per drive.
module sector_cache_adam #(
  parameter int DRIVE_NUM = 0,
  parameter int SLOT_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [63:0] img_size,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic        sd_buff_wr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  output logic        disk_present,
  input  logic [31:0] disk_sector,
  input  logic        disk_load,
  output logic        disk_sector_loaded,
  input  logic [8:0]  disk_addr,
  input  logic        disk_wr,
  input  logic [7:0]  disk_din,
  output logic [7:0]  disk_data,
  input  logic        disk_flush,
  output logic        disk_flushed,
  output logic        disk_error
);
  localparam int NS = 1 << SLOT_BITS;
  localparam int SB = SLOT_BITS > 0 ? SLOT_BITS : 1;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, RD, FLUSH, DONE} state_t;
  if (SLOT_BITS < 0 || SLOT_BITS > 4 || DRIVE_NUM < 0) begin : g_bad_param
    $error("sector_cache_adam: parameter out of range");
  end
  state_t r_state, w_next;
  logic [63:0] r_size;
  logic [31:0] r_sector, r_lba;
  logic [31:0] r_tag [NS];
  logic [NS-1:0] r_valid, r_dirty;
  logic [SB-1:0] r_rr, r_scan, r_xfer, r_act, w_hit_slot, w_rr_next;
  logic r_ack_d, r_sd_rd, r_sd_wr, r_loaded, r_error, r_flushed, r_flush_mode, r_stale, r_present;
  logic w_ack_rise, w_ack_fall, w_hit, w_oob, w_scan_last, w_scan_dirty, w_victim_dirty;
  logic [SB+8:0] w_sd_a, w_dk_a;
  logic [7:0] r_mem [NS*512];
  logic [7:0] r_sd_q, r_disk_q;
  assign w_ack_rise = sd_ack & ~r_ack_d;
  assign w_ack_fall = ~sd_ack & r_ack_d;
  assign w_oob = ~r_present | (64'({r_sector, 9'b0}) >= r_size);
  assign w_scan_last = r_scan == SB'(NS - 1);
  assign w_scan_dirty = r_valid[r_scan] & r_dirty[r_scan];
  assign w_victim_dirty = r_valid[r_rr] & r_dirty[r_rr];
  assign w_rr_next = (r_rr == SB'(NS - 1)) ? '0 : r_rr + 1'b1;
  assign w_sd_a = {r_xfer, sd_buff_addr};
  assign w_dk_a = {r_act, disk_addr};
  assign sd_lba = r_lba;
  assign sd_rd = r_sd_rd;
  assign sd_wr = r_sd_wr;
  assign sd_buff_din = r_sd_q;
  assign disk_data = r_disk_q;
  assign disk_present = r_present;
  assign disk_sector_loaded = r_loaded;
  assign disk_flushed = r_flushed;
  assign disk_error = r_error;
  always_comb begin
    w_hit = 1'b0;
    w_hit_slot = '0;
    for (int i = 0; i < NS; i++)
      if (r_valid[i] && r_tag[i] == r_sector) begin
        w_hit = 1'b1;
        w_hit_slot = SB'(i);
      end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = disk_load ? LOOKUP : disk_flush ? FLUSH : IDLE;
      LOOKUP:  w_next = (w_oob || w_hit) ? DONE : w_victim_dirty ? WB : RD;
      WB:      w_next = !w_ack_fall ? WB : !r_flush_mode ? RD : w_scan_last ? DONE : FLUSH;
      RD:      w_next = w_ack_fall ? DONE : RD;
      FLUSH:   w_next = w_scan_dirty ? WB : w_scan_last ? DONE : FLUSH;
      DONE:    w_next = (disk_load || disk_flush) ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      {r_ack_d, r_sd_rd, r_sd_wr, r_loaded, r_error, r_flushed, r_flush_mode, r_stale, r_present} <= '0;
      r_lba <= '0;
      r_size <= '0;
      r_sector <= '0;
      r_valid <= '0;
      r_dirty <= '0;
      {r_rr, r_scan, r_xfer, r_act} <= '0;
    end else begin
      r_state <= w_next;
      r_ack_d <= sd_ack;
      r_flushed <= r_state == DONE && w_next == IDLE;
      // Requests drop as soon as the SD block has seen them; completion is the later ack fall.
      r_sd_wr <= (w_next == WB && r_state != WB) ? 1'b1 : w_ack_rise ? 1'b0 : r_sd_wr;
      r_sd_rd <= (w_next == RD && r_state != RD) ? 1'b1 : w_ack_rise ? 1'b0 : r_sd_rd;
      case (r_state)
        IDLE: begin
          r_stale <= 1'b0;
          r_scan <= '0;
          r_flush_mode <= !disk_load;
          if (disk_load) begin
            r_loaded <= 1'b0;
            r_sector <= disk_sector;
          end
        end
        LOOKUP:
          if (w_oob) r_error <= 1'b1;
          else if (w_hit) begin
            r_act <= w_hit_slot;
            r_loaded <= 1'b1;
            r_error <= 1'b0;
          end else begin
            r_xfer <= r_rr;
            r_rr <= w_rr_next;
            r_lba <= w_victim_dirty ? r_tag[r_rr] : r_sector;
          end
        WB:
          if (w_ack_fall) begin
            r_dirty[r_xfer] <= 1'b0;
            if (!r_flush_mode) r_lba <= r_sector;
            else if (!w_scan_last) r_scan <= r_scan + 1'b1;
          end
        RD:
          if (w_ack_fall) begin
            r_valid[r_xfer] <= !r_stale;
            r_tag[r_xfer] <= r_sector;
            r_act <= r_xfer;
            r_loaded <= !r_stale;
            r_error <= 1'b0;
          end
        FLUSH:
          if (w_scan_dirty) begin
            r_xfer <= r_scan;
            r_lba <= r_tag[r_scan];
          end else if (!w_scan_last) r_scan <= r_scan + 1'b1;
        default: ;
      endcase
      if (disk_wr && r_loaded) r_dirty[r_act] <= 1'b1;
      // A new image invalidates everything; a transfer already in flight finishes but its slot stays invalid.
      if (img_mounted) begin
        r_size <= img_size;
        r_present <= |img_size;
        r_valid <= '0;
        r_dirty <= '0;
        r_loaded <= 1'b0;
        if (r_state == LOOKUP || r_state == WB || r_state == RD) r_stale <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (sd_buff_wr && sd_ack) r_mem[w_sd_a] <= sd_buff_dout;
    if (disk_wr && r_loaded) r_mem[w_dk_a] <= disk_din;
    r_sd_q <= reset ? '0 : r_mem[w_sd_a];
    r_disk_q <= reset ? '0 : r_mem[w_dk_a];
  end
endmodule

// File: tb/tb_sector_cache_adam.sv
// tb_sector_cache_adam: directed bench with a behavioural cache model, SD responder and per-cycle compare.
module tb_sector_cache_adam;
  localparam int NS = 2;
  logic clk = 0, reset = 1, img_mounted = 0;
  logic [63:0] img_size = 0;
  logic [31:0] sd_lba;
  logic sd_rd, sd_wr, sd_ack = 0, sd_buff_wr = 0;
  logic [8:0] sd_buff_addr = 0, disk_addr = 0;
  logic [7:0] sd_buff_dout = 0, sd_buff_din, disk_din = 0, disk_data;
  logic disk_present, disk_load = 0, disk_sector_loaded, disk_wr = 0, disk_flush = 0, disk_flushed, disk_error;
  logic [31:0] disk_sector = 0;

  sector_cache_adam #(.DRIVE_NUM(0), .SLOT_BITS(1)) dut (
    .clk(clk), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_wr(sd_buff_wr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .disk_present(disk_present), .disk_sector(disk_sector),
    .disk_load(disk_load), .disk_sector_loaded(disk_sector_loaded), .disk_addr(disk_addr),
    .disk_wr(disk_wr), .disk_din(disk_din), .disk_data(disk_data), .disk_flush(disk_flush),
    .disk_flushed(disk_flushed), .disk_error(disk_error));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit busy = 1, sd_busy = 0;
  bit exp_wr[$], log_wr[$];
  logic [31:0] exp_lba[$], log_lba[$];
  bit m_valid[NS], m_dirty[NS];
  logic [31:0] m_tag[NS];
  int m_rr = 0, m_act = 0;
  bit m_loaded = 0, m_err = 0, m_present = 0;
  longint m_size = 0;
  logic [7:0] m_bytes[longint];
  logic [7:0] sd_store[longint];

  function automatic logic [7:0] img_byte(longint l, int a);
    return 8'((l * 16 + a) & 255) ^ 8'hA5;
  endfunction
  function automatic logic [7:0] sd_byte(longint l, int a);
    return sd_store.exists(l * 512 + a) ? sd_store[l * 512 + a] : img_byte(l, a);
  endfunction
  function automatic logic [7:0] exp_byte(longint s, int a);
    return m_bytes.exists(s * 512 + a) ? m_bytes[s * 512 + a] : sd_byte(s, a);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void m_load(logic [31:0] s);
    int v;
    m_loaded = 0;
    if (!m_present || longint'(s) * 512 >= m_size) begin
      m_err = 1;
      return;
    end
    for (int i = 0; i < NS; i++)
      if (m_valid[i] && m_tag[i] == s) begin
        m_act = i; m_loaded = 1; m_err = 0;
        return;
      end
    v = m_rr;
    m_rr = (m_rr + 1) % NS;
    if (m_valid[v] && m_dirty[v]) begin
      exp_wr.push_back(1); exp_lba.push_back(m_tag[v]); m_dirty[v] = 0;
    end
    exp_wr.push_back(0); exp_lba.push_back(s);
    m_valid[v] = 1; m_tag[v] = s; m_act = v; m_loaded = 1; m_err = 0;
  endfunction

  task automatic mount(longint sz);
    busy = 1;
    m_size = sz; m_present = sz != 0; m_loaded = 0;
    foreach (m_valid[i]) begin m_valid[i] = 0; m_dirty[i] = 0; end
    m_bytes.delete();
    img_size = 64'(sz); img_mounted = 1;
    @(posedge clk); #1;
    img_mounted = 0; busy = 0;
  endtask

  task automatic do_load(logic [31:0] s, output int lat);
    int n = 0, fl = 0;
    bit want_err;
    busy = 1;
    m_load(s);
    want_err = m_err;
    disk_sector = s; disk_load = 1;
    do begin @(posedge clk); #1; n++; end
    while ((n < 2 || !(want_err ? disk_error : disk_sector_loaded)) && n < 5000);
    check("load_timeout", n >= 5000, 0);
    lat = n; disk_load = 0;
    repeat (4) begin @(posedge clk); #1; if (disk_flushed) fl++; end
    check("load_flushed_once", fl, 1);
    busy = 0;
  endtask

  task automatic do_write(logic [8:0] a, logic [7:0] d);
    busy = 1;
    if (m_loaded) begin
      m_dirty[m_act] = 1;
      m_bytes[longint'(m_tag[m_act]) * 512 + a] = d;
    end
    disk_addr = a; disk_din = d; disk_wr = 1;
    @(posedge clk); #1;
    disk_wr = 0; busy = 0;
  endtask

  task automatic rd(logic [8:0] a, output logic [7:0] d);
    disk_addr = a;
    @(posedge clk); #1;
    d = disk_data;
    check("disk_data_model", d, exp_byte(m_tag[m_act], a));
  endtask

  task automatic do_flush();
    int n = 0, fl = 0;
    busy = 1;
    for (int i = 0; i < NS; i++)
      if (m_valid[i] && m_dirty[i]) begin
        exp_wr.push_back(1); exp_lba.push_back(m_tag[i]); m_dirty[i] = 0;
      end
    disk_flush = 1;
    do begin @(posedge clk); #1; n++; if (disk_flushed) fl++; end
    while ((n < 4 || exp_wr.size() != 0 || sd_busy) && n < 5000);
    check("flush_timeout", n >= 5000, 0);
    repeat (2) begin @(posedge clk); #1; if (disk_flushed) fl++; end
    disk_flush = 0;
    repeat (4) begin @(posedge clk); #1; if (disk_flushed) fl++; end
    check("flush_flushed_once", fl, 1);
    busy = 0;
  endtask

  // SD block: serves each request, checks write-back bytes against the model's cache contents
  bit rs_w;
  logic [31:0] rs_l;
  int rs_bad;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!reset && (sd_rd || sd_wr)) begin
        rs_w = sd_wr; rs_l = sd_lba; rs_bad = 0;
        log_wr.push_back(rs_w); log_lba.push_back(rs_l);
        sd_busy = 1;
        repeat (2) @(posedge clk);
        #1 sd_ack = 1;
        for (int a = 0; a < 512; a++) begin
          sd_buff_addr = 9'(a);
          if (!rs_w) begin sd_buff_dout = sd_byte(rs_l, a); sd_buff_wr = 1; end
          @(posedge clk); #1;
          if (rs_w) begin
            if (sd_buff_din !== exp_byte(rs_l, a)) rs_bad++;
            sd_store[longint'(rs_l) * 512 + a] = exp_byte(rs_l, a);
          end
        end
        sd_buff_wr = 0; sd_ack = 0;
        if (rs_w) check("wb_data_bytes_bad", rs_bad, 0);
        repeat (2) @(posedge clk);
        #1 sd_busy = 0;
      end
    end
  end

  bit p_rd = 0, p_wr = 0, ew;
  logic [31:0] el;
  always @(negedge clk) begin
    if (!reset) begin
      if ((sd_rd && !p_rd) || (sd_wr && !p_wr)) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL sd_req unexpected wr=%0d lba=%0d", sd_wr, sd_lba);
        end else begin
          ew = exp_wr.pop_front(); el = exp_lba.pop_front();
          if (ew != sd_wr || el != sd_lba) begin
            errors++;
            $display("FAIL sd_req got wr=%0d lba=%0d want wr=%0d lba=%0d", sd_wr, sd_lba, ew, el);
          end
        end
      end
      check("rd_wr_exclusive", sd_rd & sd_wr, 0);
      if (!busy)
        check("status_present_loaded_error_flushed", {disk_present, disk_sector_loaded, disk_error, disk_flushed},
              {m_present, m_loaded, m_err, 1'b0});
    end
    p_rd = sd_rd; p_wr = sd_wr;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int lat, n0;
  logic [7:0] d;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {sd_rd, sd_wr, disk_sector_loaded, disk_error, disk_flushed, disk_present}, 0);
    check("rst_lba", sd_lba, 0);
    check("rst_disk_data", disk_data, 0);
    reset = 0; busy = 0;
    // 1: cold miss
    mount(64'd1 << 20);
    do_load(5, lat);
    check("t1_ops", log_wr.size(), 1);
    check("t1_op_rd_lba", {log_wr[0], log_lba[0]}, {1'b0, 32'd5});
    rd(3, d); check("t1_byte3_literal", d, 8'hF6);
    rd(0, d); rd(511, d); rd(200, d);
    // 2: hit, no SD traffic
    do_load(5, lat);
    check("t2_hit_latency", lat, 2);
    check("t2_no_ops", log_wr.size(), 1);
    // 3: dirty victim written back before the refill
    do_load(1, lat);
    do_write(0, 8'h11); do_write(1, 8'h22); do_write(511, 8'hEE);
    do_load(2, lat);
    do_load(4, lat);
    n0 = log_wr.size();
    check("t3_wb_first", {log_wr[n0-2], log_lba[n0-2]}, {1'b1, 32'd1});
    check("t3_rd_second", {log_wr[n0-1], log_lba[n0-1]}, {1'b0, 32'd4});
    do_load(1, lat);
    rd(0, d); check("t3_wb_roundtrip_a0", d, 8'h11);
    rd(511, d); check("t3_wb_roundtrip_a511", d, 8'hEE);
    rd(1, d);
    // 4: flush walks slots in order
    do_load(9, lat); do_write(5, 8'h99);
    do_load(7, lat); do_write(0, 8'h77);
    n0 = log_wr.size();
    do_flush();
    check("t4_flush_ops", log_wr.size(), n0 + 2);
    check("t4_wb7", {log_wr[n0], log_lba[n0]}, {1'b1, 32'd7});
    check("t4_wb9", {log_wr[n0+1], log_lba[n0+1]}, {1'b1, 32'd9});
    check("t4_loaded_kept", disk_sector_loaded, 1);
    n0 = log_wr.size();
    do_flush();
    check("t4_clean_flush_no_ops", log_wr.size(), n0);
    // 5: bounds checking
    mount(2048);
    n0 = log_wr.size();
    do_load(4, lat);
    check("t5_oob_error", {disk_error, disk_sector_loaded}, 2'b10);
    check("t5_oob_no_ops", log_wr.size(), n0);
    do_load(3, lat);
    check("t5_inb_ok", {disk_error, disk_sector_loaded}, 2'b01);
    check("t5_inb_rd", log_lba[log_lba.size()-1], 3);
    do_load(7, lat);
    check("t5_oob7_error", disk_error, 1);
    mount(64'd1 << 20);
    do_load(7, lat);
    rd(0, d); check("t5_flushed_data_back", d, 8'h77);
    // 6: reset in the middle of a refill
    busy = 1;
    m_load(100);
    disk_sector = 100; disk_load = 1;
    @(posedge clk); #1;
    disk_load = 0;
    n0 = 0;
    while (!sd_ack && n0 < 100) begin @(posedge clk); #1; n0++; end
    check("t6_ack_seen", sd_ack, 1);
    repeat (20) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    check("t6_rst_rd_loaded", {sd_rd, sd_wr, disk_sector_loaded, disk_present}, 0);
    check("t6_rst_lba", sd_lba, 0);
    reset = 0;
    foreach (m_valid[i]) begin m_valid[i] = 0; m_dirty[i] = 0; end
    m_rr = 0; m_loaded = 0; m_err = 0; m_present = 0; m_size = 0;
    m_bytes.delete();
    n0 = 0;
    while (sd_busy && n0 < 2000) begin @(posedge clk); #1; n0++; end
    check("t6_sd_idle", sd_busy, 0);
    busy = 0;
    mount(64'd1 << 20);
    n0 = log_wr.size();
    do_load(100, lat);
    check("t6_reload_misses", log_wr.size(), n0 + 1);
    check("t6_reload_rd100", {log_wr[n0], log_lba[n0]}, {1'b0, 32'd100});
    rd(9, d);
    check("exp_queue_drained", exp_wr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
